fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch path. It issues word-aligned requests to instruction memory, forwards each response to the fetch buffer's write port, and flushes and realigns the buffer on a control-flow redirect. It also discards stale in-flight responses and holds one response while the buffer reports stall, so no fetched word is lost or duplicated. It sits between the pipeline's redirect source (execute/CSR), instruction memory and the buffer.

---
 rtl/fetch_ctrl_pkg.sv | 55 +++++
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and constants for the instruction-fetch
//               sequencer: FSM state encoding, input/output bundles, the
//               register record and the configured reset address.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_ctrl_pkg;

    // Byte address fetched out of reset. Bit 1 selects the initial halfword.
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // ready to issue a request
        S_WAIT = 2'd1,  // one request outstanding, response will be forwarded
        S_DROP = 2'd2,  // one stale request outstanding, response is discarded
        S_HOLD = 2'd3   // response captured while the buffer was stalled
    } fetch_state_type;

    // Redirect source plus instruction-memory response.
    typedef struct packed {
        logic        redir_valid;
        logic [31:0] redir_pc;
        logic        imem_ready;
        logic [31:0] imem_rdata;
        logic        buf_stall;
    } fetch_ctrl_in_type;

    // Instruction-memory request plus buffer write port. The buffer-side
    // fields line up with the buffer's own input record.
    typedef struct packed {
        logic        imem_valid;
        logic [31:0] imem_addr;
        logic        ready;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        clear;
        logic        align;
    } fetch_ctrl_out_type;

    typedef struct packed {
        fetch_state_type state;
        logic [31:0]     fetch_pc;   // next address to request
        logic [31:0]     req_pc;     // address of the outstanding request
        logic [31:0]     hold_pc;    // address of the held response
        logic [31:0]     hold_data;  // held response word
    } fetch_reg_type;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Issues word-aligned requests to
//               instruction memory (one outstanding at a time), forwards each
//               response to the fetch buffer, flushes/realigns the buffer on
//               a redirect, discards stale responses and holds one response
//               while the buffer is stalled.
// Ports       : clock, reset       - clock, synchronous active-high reset
//               redir_valid/pc     - control-flow redirect from execute/CSR
//               imem_valid/addr    - memory request (accepted same cycle)
//               imem_ready/rdata   - memory response
//               buf_ready/pc/rdata - buffer write port
//               buf_clear/align    - buffer flush and halfword alignment
//               buf_stall          - buffer full, no write allowed
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        buf_ready,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_rdata,
    output logic        buf_clear,
    output logic        buf_align,
    input  logic        buf_stall
);

    fetch_ctrl_in_type  w_in;
    fetch_ctrl_out_type w_out;
    fetch_reg_type      r_q;
    fetch_reg_type      r_d;
    logic               w_unused;

    assign w_in.redir_valid = redir_valid;
    assign w_in.redir_pc    = redir_pc;
    assign w_in.imem_ready  = imem_ready;
    assign w_in.imem_rdata  = imem_rdata;
    assign w_in.buf_stall   = buf_stall;

    // Redirect targets are halfword addresses; byte bit 0 carries no meaning.
    assign w_unused = w_in.redir_pc[0];

    always_comb begin
        r_d   = r_q;
        w_out = '0;

        if (reset) begin
            w_out.clear = 1'b1;
            w_out.align = RESET_PC[1];
        end else if (w_in.redir_valid) begin
            // Flush and realign immediately; nothing is issued or written.
            w_out.clear    = 1'b1;
            w_out.align    = w_in.redir_pc[1];
            r_d.fetch_pc   = word_align(w_in.redir_pc);
            case (r_q.state)
                // A request is in flight: absorb its response later unless
                // it is arriving right now, in which case it is dropped here.
                // DROP follows the same rule so a stale response that lands
                // on a second redirect cannot leave the FSM waiting forever.
                S_WAIT, S_DROP: r_d.state = w_in.imem_ready ? S_REQ : S_DROP;
                default:        r_d.state = S_REQ;
            endcase
        end else begin
            case (r_q.state)
                S_REQ: begin
                    if (!w_in.buf_stall) begin
                        w_out.imem_valid = 1'b1;
                        w_out.imem_addr  = r_q.fetch_pc;
                        r_d.req_pc       = r_q.fetch_pc;
                        r_d.fetch_pc     = r_q.fetch_pc + 32'd4;
                        r_d.state        = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_in.imem_ready) begin
                        if (!w_in.buf_stall) begin
                            // Forward and issue the next request in the same
                            // cycle to sustain one word per cycle.
                            w_out.ready      = 1'b1;
                            w_out.pc         = r_q.req_pc;
                            w_out.rdata      = w_in.imem_rdata;
                            w_out.imem_valid = 1'b1;
                            w_out.imem_addr  = r_q.fetch_pc;
                            r_d.req_pc       = r_q.fetch_pc;
                            r_d.fetch_pc     = r_q.fetch_pc + 32'd4;
                        end else begin
                            r_d.hold_pc   = r_q.req_pc;
                            r_d.hold_data = w_in.imem_rdata;
                            r_d.state     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_in.buf_stall) begin
                        w_out.ready = 1'b1;
                        w_out.pc    = r_q.hold_pc;
                        w_out.rdata = r_q.hold_data;
                        r_d.state   = S_REQ;
                    end
                end
                S_DROP: begin
                    if (w_in.imem_ready) begin
                        r_d.state = S_REQ;
                    end
                end
                default: r_d.state = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q.state     <= S_REQ;
            r_q.fetch_pc  <= word_align(RESET_PC);
            r_q.req_pc    <= '0;
            r_q.hold_pc   <= '0;
            r_q.hold_data <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign imem_valid = w_out.imem_valid;
    assign imem_addr  = w_out.imem_addr;
    assign buf_ready  = w_out.ready;
    assign buf_pc     = w_out.pc;
    assign buf_rdata  = w_out.rdata;
    assign buf_clear  = w_out.clear;
    assign buf_align  = w_out.align;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A directed per-cycle
//               vector table covers reset, pipelining, redirects, stall hold
//               and address wrap; a randomized phase runs a latency-variable
//               memory model against an address-stream scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        buf_ready;
    logic [31:0] buf_pc;
    logic [31:0] buf_rdata;
    logic        buf_clear;
    logic        buf_align;
    logic        buf_stall = 1'b0;

    fetch_ctrl #(.RESET_PC(32'h0000_0102)) dut (
        .clock       (clock),
        .reset       (reset),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_valid  (imem_valid),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .buf_ready   (buf_ready),
        .buf_pc      (buf_pc),
        .buf_rdata   (buf_rdata),
        .buf_clear   (buf_clear),
        .buf_align   (buf_align),
        .buf_stall   (buf_stall)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory contents as a function of address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        ir;
        logic [31:0] id;
        logic        st;
        logic        e_iv;
        logic [31:0] e_ia;
        logic        e_br;
        logic [31:0] e_bpc;
        logic [31:0] e_bd;
        logic        e_clr;
        logic        e_al;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic rv, input logic [31:0] rpc,
        input logic ir, input logic [31:0] id, input logic st,
        input logic e_iv, input logic [31:0] e_ia,
        input logic e_br, input logic [31:0] e_bpc, input logic [31:0] e_bd,
        input logic e_clr, input logic e_al);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.ir = ir; v.id = id; v.st = st;
        v.e_iv = e_iv; v.e_ia = e_ia; v.e_br = e_br; v.e_bpc = e_bpc;
        v.e_bd = e_bd; v.e_clr = e_clr; v.e_al = e_al;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic        pend;
        logic [31:0] paddr;
        int          due;
        logic [31:0] exp_req;
        logic [31:0] exp_buf;
        int          idle;

        // rst rv rpc ir id st | iv ia br bpc bd clr al
        // Reset, then back-to-back fetches with 1-cycle memory.
        vecs.push_back(mk(1,0,32'h0,0,32'h0,0,          0,32'h0,0,32'h0,32'h0,1,1));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          1,32'h100,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0100,0,  1,32'h104,1,32'h100,32'hD000_0100,0,0));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0104,0,  1,32'h108,1,32'h104,32'hD000_0104,0,0));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0108,0,  1,32'h10C,1,32'h108,32'hD000_0108,0,0));
        // Redirect to 0x40 while 0x10C is in flight; stale response dropped.
        vecs.push_back(mk(0,1,32'h40,0,32'h0,0,         0,32'h0,0,32'h0,32'h0,1,0));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_010C,0,  0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          1,32'h40,0,32'h0,32'h0,0,0));
        // Redirect to 0x2006 while 0x40 is in flight.
        vecs.push_back(mk(0,1,32'h2006,0,32'h0,0,       0,32'h0,0,32'h0,32'h0,1,1));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0040,0,  0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          1,32'h2004,0,32'h0,32'h0,0,0));
        // Response arrives under a 3-cycle stall, presented once afterwards.
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_2004,1,  0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,1,          0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,1,          0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          0,32'h0,1,32'h2004,32'hD000_2004,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          1,32'h2008,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          0,32'h0,0,32'h0,32'h0,0,0));
        // Redirect coinciding with the response: no DROP, then address wrap.
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,1,32'hD000_2008,0, 0,32'h0,0,32'h0,32'h0,1,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          1,32'hFFFF_FFFC,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,1,32'hDFFF_FFFC,0,  1,32'h0,1,32'hFFFF_FFFC,32'hDFFF_FFFC,0,0));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0000,0,  1,32'h4,1,32'h0,32'hD000_0000,0,0));
        // Two redirects back to back into DROP: last target wins.
        vecs.push_back(mk(0,1,32'h300,0,32'h0,0,        0,32'h0,0,32'h0,32'h0,1,0));
        vecs.push_back(mk(0,1,32'h402,0,32'h0,0,        0,32'h0,0,32'h0,32'h0,1,1));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0004,0,  0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          1,32'h400,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0400,0,  1,32'h404,1,32'h400,32'hD000_0400,0,0));
        // Redirect out of HOLD discards the held word; REQ respects stall.
        vecs.push_back(mk(0,0,32'h0,1,32'hD000_0404,1,  0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,1,32'h500,0,32'h0,1,        0,32'h0,0,32'h0,32'h0,1,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,1,          0,32'h0,0,32'h0,32'h0,0,0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,0,          1,32'h500,0,32'h0,32'h0,0,0));

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            @(posedge clock); #1;
            reset       = vecs[i].rst;
            redir_valid = vecs[i].rv;
            redir_pc    = vecs[i].rpc;
            imem_ready  = vecs[i].ir;
            imem_rdata  = vecs[i].id;
            buf_stall   = vecs[i].st;
            #3;
            chk($sformatf("row%0d_imem", i), {imem_valid, imem_addr},
                {vecs[i].e_iv, vecs[i].e_ia});
            chk($sformatf("row%0d_buf", i), {buf_ready, buf_pc, buf_rdata},
                {vecs[i].e_br, vecs[i].e_bpc, vecs[i].e_bd});
            chk($sformatf("row%0d_ctl", i), {buf_clear, buf_align},
                {vecs[i].e_clr, vecs[i].e_al});
        end

        // ---------------- randomized phase ----------------
        @(posedge clock); #1;
        reset = 1'b1; redir_valid = 1'b0; imem_ready = 1'b0; buf_stall = 1'b0;
        @(posedge clock); #1;
        reset   = 1'b0;
        pend    = 1'b0;
        paddr   = '0;
        due     = 0;
        exp_req = 32'h100;
        exp_buf = 32'h100;
        idle    = 0;

        for (int c = 0; c < 4000; c++) begin
            redir_valid = ($urandom_range(0, 19) == 0);
            redir_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                      : $urandom;
            buf_stall   = ($urandom_range(0, 9) < 3);
            imem_ready  = pend && (due == c);
            imem_rdata  = imem_ready ? word_of(paddr) : $urandom;
            #3;

            if (redir_valid) begin
                chk("redir_clear", {127'd0, buf_clear}, 128'd1);
                chk("redir_align", {127'd0, buf_align}, {127'd0, redir_pc[1]});
                chk("redir_quiet", {126'd0, imem_valid, buf_ready}, 128'd0);
            end else begin
                chk("no_clear", {127'd0, buf_clear}, 128'd0);
            end

            if (buf_ready) begin
                chk("write_under_stall", {127'd0, buf_stall}, 128'd0);
                chk("buf_pc", {96'd0, buf_pc}, {96'd0, exp_buf});
                chk("buf_rdata", {96'd0, buf_rdata}, {96'd0, word_of(exp_buf)});
                exp_buf = exp_buf + 32'd4;
                idle = 0;
            end else begin
                chk("buf_idle", {64'd0, buf_pc, buf_rdata}, 128'd0);
                idle++;
            end

            if (imem_valid) begin
                chk("one_outstanding", {127'd0, pend && !imem_ready}, 128'd0);
                chk("imem_addr", {96'd0, imem_addr}, {96'd0, exp_req});
                exp_req = exp_req + 32'd4;
            end else begin
                chk("imem_idle", {96'd0, imem_addr}, 128'd0);
            end

            if (redir_valid) begin
                exp_req = {redir_pc[31:2], 2'b00};
                exp_buf = {redir_pc[31:2], 2'b00};
                idle = 0;
            end

            if (idle > 60) begin
                n_checks++;
                $display("FAIL progress: got %0d idle cycles expected at most 60", idle);
                idle = 0;
            end

            // Memory side of the clock edge.
            if (imem_ready) pend = 1'b0;
            if (imem_valid) begin
                pend  = 1'b1;
                paddr = imem_addr;
                due   = c + int'($urandom_range(1, 3));
            end

            @(posedge clock); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
